// File: rtl/rf_write_arbiter.sv
// Two-source arbiter for the register file's single write port: fixed priority to
// the ALU path, starvation guard for the load path, registered write stage, x0 drop.
module rf_write_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              grant_id,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DROP_W = 8;
  localparam logic [CNT_W-1:0]  WAIT_LIM = CNT_W'(MAX_WAIT);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic              src;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  logic [CNT_W-1:0] wait_cnt;
  logic             starved_c;
  logic             xfer0_c;
  logic             xfer1_c;
  logic             xfer_c;
  wb_req_t          win_c;

  // Grant: requester 1 only wins a contended cycle once it has waited MAX_WAIT cycles.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    starved_c  = (wait_cnt == WAIT_LIM);
    if (reset && !stall) begin
      if (req1_valid && (!req0_valid || starved_c)) begin
        req1_ready = 1'b1;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end
    end
  end

  assign xfer0_c = req0_valid & req0_ready;
  assign xfer1_c = req1_valid & req1_ready;
  assign xfer_c  = xfer0_c | xfer1_c;

  always_comb begin
    win_c.src  = 1'b0;
    win_c.addr = req0_addr;
    win_c.data = req0_data;
    if (xfer1_c) begin
      win_c.src  = 1'b1;
      win_c.addr = req1_addr;
      win_c.data = req1_data;
    end
  end

  // Refused-cycle counter; stall cycles neither count nor clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (xfer1_c) begin
      wait_cnt <= '0;
    end else if (req1_valid && !req1_ready && !stall && !starved_c) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Write stage: one registered beat towards WE3/A3/WD3; x0 writes are counted, not issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wd    <= '0;
      grant_id <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      if (xfer_c && (win_c.addr != '0)) begin
        rf_we    <= 1'b1;
        rf_addr  <= win_c.addr;
        rf_wd    <= win_c.data;
        grant_id <= win_c.src;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (xfer_c && (win_c.addr == '0) && (drop_cnt != DROP_MAX)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a small register-file model on the write port.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic        grant_id;
  logic [7:0]  drop_cnt;

  logic [31:0] rf_mem [32];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd), .grant_id(grant_id), .drop_cnt(drop_cnt)
  );

  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_wd;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ready(input string tag, input logic r0, input logic r1);
    #1;
    check_eq({tag, "_r0"}, 32'(req0_ready), 32'(r0));
    check_eq({tag, "_r1"}, 32'(req1_ready), 32'(r1));
    check_eq({tag, "_excl"}, 32'(req0_ready & req1_ready), 32'd0);
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic g);
    check_eq({tag, "_we"}, 32'(rf_we), 32'(we));
    check_eq({tag, "_addr"}, 32'(rf_addr), 32'(a));
    check_eq({tag, "_wd"}, rf_wd, d);
    check_eq({tag, "_gid"}, 32'(grant_id), 32'(g));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    reset = 1'b0; stall = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h0;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h0;

    // Reset values, readies gated by reset even with both valid.
    tick();
    check_ready("rst", 1'b0, 1'b0);
    check_wr("rst", 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("rst_drop", 32'(drop_cnt), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Single source write and register-file latency.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    check_ready("single", 1'b1, 1'b0);
    tick();
    req0_valid = 1'b0;
    check_wr("single", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    tick();
    check_eq("single_we_off", 32'(rf_we), 32'd0);
    check_eq("single_rf5", rf_mem[5], 32'hDEADBEEF);

    // Back-to-back writes, one cycle delayed.
    for (int i = 1; i <= 3; i++) begin
      req0_valid = 1'b1; req0_addr = 5'(i); req0_data = 32'(i * 'h11);
      check_ready("b2b", 1'b1, 1'b0);
      tick();
      check_wr("b2b", 1'b1, 5'(i), 32'(i * 'h11), 1'b0);
    end
    req0_valid = 1'b0;
    tick();
    check_eq("b2b_we_off", 32'(rf_we), 32'd0);
    check_eq("b2b_rf3", rf_mem[3], 32'h33);

    // Contention: grant pattern 0,0,0,0,1 repeating.
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hAAAA0000;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hBBBB0000;
    for (int i = 0; i < 10; i++) begin
      logic g;
      g = ((i % 5) == 4);
      check_ready("cont", !g, g);
      tick();
      check_wr("cont", 1'b1, g ? 5'd11 : 5'd10, g ? 32'hBBBB0000 : 32'hAAAA0000, g);
    end

    // Stall with wait_cnt at 2: no grants, count frozen, then 0,0,1 on release.
    for (int i = 0; i < 2; i++) begin
      check_ready("prestall", 1'b1, 1'b0);
      tick();
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_ready("stall", 1'b0, 1'b0);
      tick();
      check_eq("stall_we", 32'(rf_we), 32'd0);
    end
    stall = 1'b0;
    check_ready("rel0", 1'b1, 1'b0);
    tick();
    check_wr("rel0", 1'b1, 5'd10, 32'hAAAA0000, 1'b0);
    check_ready("rel1", 1'b1, 1'b0);
    tick();
    check_ready("rel2", 1'b0, 1'b1);
    tick();
    check_wr("rel2", 1'b1, 5'd11, 32'hBBBB0000, 1'b1);

    // x0 suppression and drop counter saturation.
    req0_valid = 1'b0;
    req1_addr = 5'd0; req1_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      check_ready("x0", 1'b0, 1'b1);
      tick();
      check_wr("x0", 1'b0, 5'd11, 32'hBBBB0000, 1'b1);
    end
    check_eq("x0_drop3", 32'(drop_cnt), 32'd3);
    check_eq("x0_rf0", rf_mem[0], 32'h0);
    for (int i = 0; i < 297; i++) tick();
    check_eq("x0_drop_sat", 32'(drop_cnt), 32'd255);
    req1_valid = 1'b0;
    tick();
    check_eq("x0_drop_hold", 32'(drop_cnt), 32'd255);

    // Asynchronous reset while a write sits in the write stage.
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA5A5A5A5;
    check_ready("arst_acc", 1'b1, 1'b0);
    tick();
    check_wr("arst_stage", 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0);
    reset = 1'b0;
    #1;
    check_wr("arst", 1'b0, 5'd0, 32'h0, 1'b0);
    check_eq("arst_drop", 32'(drop_cnt), 32'd0);
    check_ready("arst", 1'b0, 1'b0);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_eq("arst_post_we", 32'(rf_we), 32'd0);
    tick();
    check_eq("arst_rf7", rf_mem[7], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters: the ALU writeback path (requester 0) and the load/memory writeback path (requester 1). Fixed priority to requester 0 with a starvation guard for requester 1, a registered write stage driving the register file, suppression of writes to x0, and a global stall. Sits between the writeback sources and the register file's write port.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- MAX_WAIT, 4, consecutive refused cycles after which requester 1 wins; legal range 1..15

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- stall  in  1  1 = no grants this cycle
- req0_valid  in  1  ALU writeback request
- req0_addr  in  ADDR_W  destination register
- req0_data  in  DATA_W  write data
- req0_ready  out  1  combinational grant to requester 0
- req1_valid  in  1  load writeback request
- req1_addr  in  ADDR_W  destination register
- req1_data  in  DATA_W  write data
- req1_ready  out  1  combinational grant to requester 1
- rf_we  out  1  to register file WE3
- rf_addr  out  ADDR_W  to A3
- rf_wd  out  DATA_W  to WD3
- grant_id  out  1  source of the write currently on rf_* (0/1)
- drop_cnt  out  8  count of accepted writes to x0, saturating at 255

## Operation
- Transfer on a requester = valid & ready at a rising edge. Requesters hold addr/data stable while valid & !ready.
- Grant (combinational, per cycle):
  - stall=1 or reset asserted: req0_ready=req1_ready=0.
  - only one valid: that requester gets ready=1.
  - both valid: requester 1 if wait_cnt==MAX_WAIT, else requester 0.
  - at most one ready high in any cycle; ready never high without its valid.
- wait_cnt (internal, 4 bits): on each edge, cleared if requester 1 transfers; else incremented (saturating at MAX_WAIT) if req1_valid & !req1_ready & !stall; else held. Stall cycles neither count nor clear.
- Write stage (registered), at each edge:
  - transfer with addr!=0: rf_we<=1, rf_addr<=addr, rf_wd<=data, grant_id<=source.
  - transfer with addr==0: rf_we<=0, rf_addr/rf_wd/grant_id hold, drop_cnt<=drop_cnt+1 unless already 255.
  - no transfer: rf_we<=0, other write-stage outputs hold.
- Max sustained throughput: one write per cycle. No internal queuing beyond the single write stage.
- Reset (asynchronous, reset=0): rf_we=0, rf_addr=0, rf_wd=0, grant_id=0, drop_cnt=0, wait_cnt=0. Both readies are 0 while reset=0. Reset mid-transfer discards the in-flight write; the register file does not see it.

## Timing
- Accept at edge N -> rf_we/rf_addr/rf_wd valid from edge N to edge N+1 -> register file captures at edge N+1 -> combinational read of that register returns the new value after edge N+1.
- Latency from accept to register-file update: 2 edges counting the accept edge (1 cycle of registered delay).
- Starvation bound: with req0 continuously valid and no stall, requester 1 waits exactly MAX_WAIT cycles, then is granted in cycle MAX_WAIT+1.
- Stall asserted in cycle N: no transfer at edge N, so rf_we=0 in cycle N+1. A write already in the write stage completes regardless of stall.
- Reset deassertion: first grant possible in the first cycle with reset=1. First rf_we possible one edge later.

## Test plan
- Single source: req0 valid, addr=5, data=0xDEADBEEF for one cycle -> req0_ready=1 same cycle; next cycle rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF, grant_id=0; rf_we=0 after.
- Contention with MAX_WAIT=4: both valid continuously, distinct data -> grant pattern 0,0,0,0,1 repeating; wait_cnt clears after each req1 grant; no cycle has both readies high.
- x0 suppression: req1 writes addr=0, data=0x1234 three times -> rf_we stays 0, rf_addr/rf_wd hold, drop_cnt=3; 300 such writes -> drop_cnt=255.
- Stall: both valid, stall=1 for 3 cycles -> both readies 0, rf_we=0, wait_cnt unchanged; on release, req0 granted first unless wait_cnt==MAX_WAIT.
- Asynchronous reset mid-operation: accept addr=7, data=0xA5A5A5A5, then drop reset to 0 before the next edge -> rf_we=0 immediately, all outputs at reset values, readies 0; after release, register 7 is not written.
- Back-to-back: req0 issues addr 1,2,3 on consecutive cycles with data 0x11,0x22,0x33 -> rf_we=1 for 3 consecutive cycles with matching addr/data, one cycle delayed.
